// File: rtl/fsm_mon_pkg.sv
// Shared types and constants for the sequencer output monitor.
package fsm_mon_pkg;

    // Monitor FSM: waiting for a 0, locked on, or locked on with an error seen
    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        ERR    = 2'd2
    } mon_state_t;

    // Last state of the 0->1->2->3 loop and the only state that drives out=1
    localparam logic [1:0] SEQ_LAST  = 2'd3;
    localparam logic [1:0] OUT_STATE = 2'd2;

    // Successor of a sequencer state, wrapping 3 -> 0
    function automatic logic [1:0] seq_next(input logic [1:0] s);
        return s + 2'd1;
    endfunction

endpackage

// File: rtl/fsm_mon_dwell_ctr.sv
// Hold (dwell) counter: counts consecutive hold samples and reports the
// sample that completes STUCK_LIMIT holds. Saturates so long holds keep hitting.
module fsm_mon_dwell_ctr #(
    parameter int STUCK_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);
    import fsm_mon_pkg::*;

    localparam int DW = $clog2(STUCK_LIMIT + 1);
    localparam logic [DW-1:0] HIT_AT  = DW'(STUCK_LIMIT - 1);
    localparam logic [DW-1:0] CNT_MAX = DW'(STUCK_LIMIT);

    logic [DW-1:0] r_cnt;

    // Count holds; clear wins, saturate at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // This hold is the STUCK_LIMIT-th (or later) consecutive one
    assign o_hit = i_inc && !i_clr && (r_cnt >= HIT_AT);

endmodule

// File: rtl/fsm_seq_monitor.sv
// Passive monitor for the 4-state sequencer (0->1->2->3->0, out==1 only in 2).
// Flags illegal jumps, wrong out and stuck states; counts completed loops.
// Optional FSMMON_ERR_STAMP_EN adds a cycle counter and err_stamp output.
module fsm_seq_monitor #(
    parameter int STUCK_LIMIT = 4,
    parameter int CNT_W       = 8
`ifdef FSMMON_ERR_STAMP_EN
    ,
    parameter int STAMP_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             dut_rst,
    input  logic [1:0]       dut_state,
    input  logic             dut_out,
    output logic             sync_ok,
    output logic             trans_err,
    output logic             out_err,
    output logic             stuck_err,
    output logic             any_err,
    output logic [CNT_W-1:0] loop_cnt
`ifdef FSMMON_ERR_STAMP_EN
    ,
    output logic [STAMP_W-1:0] err_stamp
`endif
);
    import fsm_mon_pkg::*;

    mon_state_t       r_state;
    mon_state_t       w_state_next;
    logic [1:0]       r_prev;
    logic             w_active;
    logic             w_check;
    logic             w_legal;
    logic             w_hold;
    logic             w_trans_hit;
    logic             w_out_hit;
    logic             w_stuck_hit;
    logic             w_err_now;
    logic             w_wrap;
    logic             w_trans_next;
    logic             w_out_next;
    logic             w_stuck_next;
    logic [CNT_W-1:0] w_loop_base;
    logic [CNT_W-1:0] w_loop_next;

    // Checks run only while locked on and the sequencer is live
    assign w_active    = en && !dut_rst;
    assign w_check     = (r_state != UNSYNC) && w_active;
    assign w_legal     = w_check && (dut_state == seq_next(r_prev));
    assign w_hold      = w_check && (dut_state == r_prev);
    assign w_trans_hit = w_check && !w_legal && !w_hold;
    assign w_out_hit   = w_check && (dut_out != (dut_state == OUT_STATE));
    assign w_wrap      = w_legal && (r_prev == SEQ_LAST);
    assign w_err_now   = w_trans_hit || w_out_hit || w_stuck_hit;

    // Any non-hold sample (including leaving UNSYNC) restarts the dwell count
    fsm_mon_dwell_ctr #(
        .STUCK_LIMIT (STUCK_LIMIT)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (!w_hold),
        .i_inc (w_hold),
        .o_hit (w_stuck_hit)
    );

    // Next FSM state, sticky flags and loop count; a new error beats clr
    always_comb begin
        w_state_next = r_state;
        w_trans_next = (trans_err & ~clr) | w_trans_hit;
        w_out_next   = (out_err   & ~clr) | w_out_hit;
        w_stuck_next = (stuck_err & ~clr) | w_stuck_hit;
        w_loop_base  = clr ? '0 : loop_cnt;
        w_loop_next  = w_loop_base;
        if (w_wrap && (w_loop_base != {CNT_W{1'b1}})) begin
            w_loop_next = w_loop_base + 1'b1;
        end
        case (r_state)
            UNSYNC: begin
                if (w_active && (dut_state == 2'd0)) begin
                    w_state_next = TRACK;
                end
            end
            TRACK: begin
                if (!w_active) begin
                    w_state_next = UNSYNC;
                end else if (w_err_now) begin
                    w_state_next = ERR;
                end
            end
            ERR: begin
                if (!w_active) begin
                    w_state_next = UNSYNC;
                end else if (!w_err_now && clr) begin
                    w_state_next = UNSYNC;
                end
            end
            default: begin
                w_state_next = UNSYNC;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= UNSYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered outputs and last sampled state (zero whenever not checking)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= 2'd0;
            sync_ok   <= 1'b0;
            trans_err <= 1'b0;
            out_err   <= 1'b0;
            stuck_err <= 1'b0;
            any_err   <= 1'b0;
            loop_cnt  <= '0;
        end else begin
            r_prev    <= w_check ? dut_state : 2'd0;
            sync_ok   <= (w_state_next == TRACK);
            trans_err <= w_trans_next;
            out_err   <= w_out_next;
            stuck_err <= w_stuck_next;
            any_err   <= w_trans_next | w_out_next | w_stuck_next;
            loop_cnt  <= w_loop_next;
        end
    end

`ifdef FSMMON_ERR_STAMP_EN
    logic [STAMP_W-1:0] r_cycle;

    // Free-running cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    // Capture the cycle of the first flag after reset/clr; any_err marks "already stamped"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_stamp <= '0;
        end else if (w_err_now && (!any_err || clr)) begin
            err_stamp <= r_cycle;
        end else if (clr) begin
            err_stamp <= '0;
        end
    end
`endif

endmodule
